// File: rtl/sm83_pkg.sv
// Shared types and constants for the SM83 memory bus unit.
// Consumed by sm83_addr_mux and sm83_bus_unit.
package sm83_pkg;

    typedef enum logic [2:0] {
        ADDR_PC   = 3'd0,
        ADDR_GP16 = 3'd1,
        ADDR_WZ   = 3'd2,
        ADDR_FF_C = 3'd3,
        ADDR_NONE = 3'd4
    } addr_sel_t;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_BUSY = 1'b1
    } bus_state_t;

    // Value returned for a read that never got an acknowledge.
    localparam logic [7:0] BUS_OPEN_DATA = 8'hFF;

endpackage

// File: rtl/sm83_addr_mux.sv
// Combinational address source select for the bus unit.
// addr_valid is low when the sequencer requests no memory access.
module sm83_addr_mux
    import sm83_pkg::*;
(
    input  addr_sel_t   addr_sel,
    input  logic [15:0] pc,
    input  logic [15:0] gp16,
    input  logic [15:0] wz,
    input  logic [7:0]  c_reg,
    output logic [15:0] addr,
    output logic        addr_valid
);

    always_comb begin
        addr       = 16'h0000;
        addr_valid = 1'b1;
        case (addr_sel)
            ADDR_PC:   addr = pc;
            ADDR_GP16: addr = gp16;
            ADDR_WZ:   addr = wz;
            ADDR_FF_C: addr = {8'hFF, c_reg};
            default:   addr_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/sm83_bus_unit.sv
// SM83 memory bus unit: turns sequencer strobes into a registered req/ack access.
// Optional bus timeout is compiled in with SM83_BUS_TIMEOUT_EN.
module sm83_bus_unit
    import sm83_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  addr_sel_t   addr_sel,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [7:0]  wdata,
    input  logic [15:0] pc,
    input  logic [15:0] gp16,
    input  logic [15:0] wz,
    input  logic [7:0]  c_reg,
    output logic [7:0]  rdata,
    output logic        rdata_valid,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err,
    output bus_state_t  state_dbg
);

    // Handshake: mem_req rises the cycle after the strobe and stays high with
    // we/addr/wdata stable until a cycle in which mem_ack=1; that cycle completes
    // the access and mem_req is low the next cycle. mem_ack is ignored while
    // mem_req=0.

    bus_state_t  state, state_next;
    logic [15:0] sel_addr;
    logic        sel_valid;
    logic        start;
    logic        busy;
    logic        timeout_hit;
    logic [15:0] addr_q;
    logic        we_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;

    sm83_addr_mux u_addr_mux (
        .addr_sel   (addr_sel),
        .pc         (pc),
        .gp16       (gp16),
        .wz         (wz),
        .c_reg      (c_reg),
        .addr       (sel_addr),
        .addr_valid (sel_valid)
    );

    assign busy  = (state == BUS_BUSY);
    assign start = (state == BUS_IDLE) && (rd_en || wr_en) && sel_valid;

`ifdef SM83_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt;
    logic             err_q;

    // to_cnt counts unacknowledged BUSY cycles; an ack in the limit cycle wins.
    assign timeout_hit = busy && !mem_ack && (to_cnt == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (start || (busy && (mem_ack || timeout_hit))) begin
                to_cnt <= '0;
            end else if (busy) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus_err = err_q;
`else
    assign timeout_hit = 1'b0;
    // TIMEOUT_CYCLES only matters when the timeout logic is compiled in.
    assign bus_err     = 1'b0 && (TIMEOUT_CYCLES >= 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BUS_IDLE;
            addr_q  <= 16'h0000;
            we_q    <= 1'b0;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            state <= state_next;
            if (start) begin
                addr_q  <= sel_addr;
                we_q    <= wr_en;
                wdata_q <= wdata;
            end
            if (busy && mem_ack && !we_q) begin
                rdata_q <= mem_rdata;
            end else if (timeout_hit && !we_q) begin
                rdata_q <= BUS_OPEN_DATA;
            end
        end
    end

    always_comb begin
        state_next  = state;
        stall       = 1'b0;
        rdata_valid = 1'b0;
        rdata       = rdata_q;
        case (state)
            BUS_IDLE: begin
                if (start) begin
                    stall      = 1'b1;
                    state_next = BUS_BUSY;
                end
            end
            BUS_BUSY: begin
                stall = !(mem_ack || timeout_hit);
                if (mem_ack) begin
                    state_next = BUS_IDLE;
                    if (!we_q) begin
                        rdata_valid = 1'b1;
                        rdata       = mem_rdata;
                    end
                end else if (timeout_hit) begin
                    state_next = BUS_IDLE;
                    if (!we_q) begin
                        rdata_valid = 1'b1;
                        rdata       = BUS_OPEN_DATA;
                    end
                end
            end
            default: state_next = BUS_IDLE;
        endcase
    end

    assign mem_req   = busy;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_sm83_bus_unit.sv
// Randomized scoreboard bench for sm83_bus_unit against a byte-memory model.
// Timeout scenarios are included when SM83_BUS_TIMEOUT_EN is defined.
module tb_sm83_bus_unit;
    import sm83_pkg::*;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    addr_sel_t   addr_sel;
    logic        rd_en;
    logic        wr_en;
    logic [7:0]  wdata;
    logic [15:0] pc;
    logic [15:0] gp16;
    logic [15:0] wz;
    logic [7:0]  c_reg;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        bus_err;
    bus_state_t  state_dbg;

    int checks = 0;
    int fails  = 0;

    logic [24:0] req_q[$];
    logic [7:0]  exp_q[$];
    int          delay_q[$];
    logic [7:0]  ext_mem[logic [15:0]];
    logic [7:0]  ref_mem[logic [15:0]];

    sm83_bus_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr_sel    (addr_sel),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .wdata       (wdata),
        .pc          (pc),
        .gp16        (gp16),
        .wz          (wz),
        .c_reg       (c_reg),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .bus_err     (bus_err),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ext_rd(input logic [15:0] a);
        return ext_mem.exists(a) ? ext_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    // ---------------- external memory responder ----------------
    initial begin
        bit active;
        int cnt;
        int d;
        active    = 1'b0;
        cnt       = 0;
        d         = 0;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                active  = 1'b0;
                mem_ack = 1'b0;
            end else if (mem_req) begin
                if (!active) begin
                    active = 1'b1;
                    cnt    = 0;
                    d      = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
                end else begin
                    cnt++;
                end
                mem_ack = (cnt == d);
                if (mem_ack) begin
                    if (mem_we) ext_mem[mem_addr] = mem_wdata;
                    mem_rdata = ext_rd(mem_addr);
                end else begin
                    mem_rdata = 8'($urandom);
                end
            end else begin
                active    = 1'b0;
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = 8'($urandom);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic        prev_req;
        logic [24:0] held;
        logic [24:0] e;
        logic [7:0]  last_read;
        logic [7:0]  er;
        prev_req  = 1'b0;
        held      = '0;
        last_read = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req  = 1'b0;
                last_read = 8'h00;
            end else begin
                if (mem_req && !prev_req) begin
                    if (req_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_req: got addr %0h expected no request", mem_addr);
                    end else begin
                        e = req_q.pop_front();
                        check("req_we", mem_we, e[24]);
                        check("req_addr", mem_addr, e[23:8]);
                        check("req_wdata", mem_wdata, e[7:0]);
                    end
                    held = {mem_we, mem_addr, mem_wdata};
                end else if (mem_req) begin
                    check("req_stable", {mem_we, mem_addr, mem_wdata}, held);
                end
                if (rdata_valid) begin
                    check("valid_stall", stall, 1'b0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_rdata_valid: got rdata %0h expected no read", rdata);
                    end else begin
                        er = exp_q.pop_front();
                        check("rdata", rdata, er);
                        last_read = er;
                    end
                end else begin
                    check("rdata_hold", rdata, last_read);
                end
                prev_req = mem_req;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_access(input addr_sel_t sel, input logic rd, input logic wr,
                             input logic [15:0] a_pc, input logic [15:0] a_gp,
                             input logic [15:0] a_wz, input logic [7:0] c,
                             input logic [7:0] wd, input int delay);
        logic [15:0] a;
        logic        v;
        logic        forced;
        int          exp_stall;
        int          n;
        bit          done;
        @(posedge clk);
        #1;
        addr_sel = sel;
        rd_en    = rd;
        wr_en    = wr;
        pc       = a_pc;
        gp16     = a_gp;
        wz       = a_wz;
        c_reg    = c;
        wdata    = wd;
        v = 1'b1;
        case (sel)
            ADDR_PC:   a = a_pc;
            ADDR_GP16: a = a_gp;
            ADDR_WZ:   a = a_wz;
            ADDR_FF_C: a = {8'hFF, c};
            default: begin a = 16'h0000; v = 1'b0; end
        endcase
        exp_stall = 0;
        if (v && (rd || wr)) begin
`ifdef SM83_BUS_TIMEOUT_EN
            forced    = (delay > TO);
            exp_stall = (forced ? TO : delay) + 1;
`else
            forced    = 1'b0;
            exp_stall = delay + 1;
`endif
            req_q.push_back({wr, a, wd});
            delay_q.push_back(delay);
            if (wr) begin
                if (!forced) ref_mem[a] = wd;
            end else begin
                exp_q.push_back(forced ? BUS_OPEN_DATA : ref_rd(a));
            end
        end
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (!stall) done = 1'b1;
            else n++;
        end
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL stall_timeout: stall still high after 64 cycles, expected release");
        end else begin
            check("stall_cycles", n, exp_stall);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rd_en    = 1'b0;
            wr_en    = 1'b0;
            addr_sel = ADDR_NONE;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        addr_sel = ADDR_NONE;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        wdata    = 8'h00;
        pc       = 16'h0000;
        gp16     = 16'h0000;
        wz       = 16'h0000;
        c_reg    = 8'h00;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_wdata", mem_wdata, 8'h00);
        check("rst_rdata", rdata, 8'h00);
        check("rst_stall", stall, 1'b0);
        check("rst_rdata_valid", rdata_valid, 1'b0);
        check("rst_bus_err", bus_err, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        ext_mem[16'h0150] = 8'h3E;
        ref_mem[16'h0150] = 8'h3E;
        do_access(ADDR_PC, 1'b1, 1'b0, 16'h0150, 16'h0, 16'h0, 8'h00, 8'h00, 0);
        idle(1);
        @(negedge clk);
        check("rdata_q_after_read", rdata, 8'h3E);

        do_access(ADDR_GP16, 1'b0, 1'b1, 16'h0, 16'hC000, 16'h0, 8'h00, 8'hA5, 3);
        idle(1);
        do_access(ADDR_FF_C, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 8'h44, 8'h00, 1);
        do_access(ADDR_PC, 1'b1, 1'b1, 16'h8000, 16'h0, 16'h0, 8'h00, 8'h5A, 0);
        do_access(ADDR_NONE, 1'b1, 1'b0, 16'h9000, 16'h0, 16'h0, 8'h00, 8'h00, 0);
        idle(1);
        do_access(ADDR_PC, 1'b1, 1'b0, 16'h0200, 16'h0, 16'h0, 8'h00, 8'h00, 0);
        do_access(ADDR_WZ, 1'b1, 1'b0, 16'h0, 16'h0, 16'h1234, 8'h00, 8'h00, 0);
        do_access(ADDR_PC, 1'b1, 1'b0, 16'h8000, 16'h0, 16'h0, 8'h00, 8'h00, 2);
        idle(2);

`ifdef SM83_BUS_TIMEOUT_EN
        do_access(ADDR_PC, 1'b1, 1'b0, 16'h0300, 16'h0, 16'h0, 8'h00, 8'h00, 100);
        idle(1);
        @(negedge clk);
        check("bus_err_set", bus_err, 1'b1);
        do_access(ADDR_GP16, 1'b0, 1'b1, 16'h0, 16'h0300, 16'h0, 8'h00, 8'h77, 100);
        do_access(ADDR_PC, 1'b1, 1'b0, 16'h0300, 16'h0, 16'h0, 8'h00, 8'h00, TO);
        idle(2);
        @(negedge clk);
        check("bus_err_sticky", bus_err, 1'b1);
`endif

        for (int k = 0; k < 150; k++) begin
            do_access(addr_sel_t'(3'($urandom_range(0, 4))),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                      16'hC000 + 16'($urandom_range(0, 7)),
                      16'hC000 + 16'($urandom_range(0, 7)),
                      16'hC004 + 16'($urandom_range(0, 7)),
                      8'($urandom_range(0, 7)), 8'($urandom),
                      int'($urandom_range(0, 6)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(2);

        // Abandon a read mid-access with an asynchronous reset.
        @(posedge clk);
        #1;
        addr_sel = ADDR_PC;
        pc       = 16'h2000;
        rd_en    = 1'b1;
        wdata    = 8'h11;
        req_q.push_back({1'b0, 16'h2000, 8'h11});
        delay_q.push_back(200);
        repeat (3) @(posedge clk);
        #3;
        check("pre_rst_mem_req", mem_req, 1'b1);
        rst_n = 1'b0;
        rd_en = 1'b0;
        #1;
        check("mid_rst_mem_req", mem_req, 1'b0);
        check("mid_rst_stall", stall, 1'b0);
        check("mid_rst_bus_err", bus_err, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        addr_sel = ADDR_NONE;
        idle(3);
        @(negedge clk);
        check("post_rst_mem_req", mem_req, 1'b0);
        check("final_bus_err", bus_err, 1'b0);
        check("req_q_empty", req_q.size(), 0);
        check("exp_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/sm83_bus_unit.md
# sm83_bus_unit

Memory bus interface for the SM83 core, directly downstream of the control sequencer. It turns the sequencer's per-cycle address select and read/write strobes into a registered request/acknowledge transaction on the external memory port. It returns read data to the datapath and stalls the sequencer until the access completes. It supports variable-latency memories and, optionally, a bus timeout.

## Interface
- TIMEOUT_CYCLES, 16: number of BUSY cycles without `mem_ack` before a forced completion. Only used when the timeout feature is compiled in. Must be ≥1.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- addr_sel  in  addr_sel_t  address source from the sequencer: PC, GP16, WZ, FF_C, NONE
- rd_en  in  1  read strobe; the OR of the sequencer's mem_to_z/w/ir/r8
- wr_en  in  1  write strobe; the OR of r8_to_mem and z_to_mem
- wdata  in  8  write data from the datapath, already selected between r8 and Z
- pc, gp16, wz  in  16 each  candidate addresses
- c_reg  in  8  C register, used for FF_C
- rdata  out  8  read data to the datapath
- rdata_valid  out  1  read data valid this cycle
- stall  out  1  holds the sequencer's step index and all its captures
- mem_req  out  1  external request
- mem_we  out  1  1 = write
- mem_addr  out  16  external address
- mem_wdata  out  8  external write data
- mem_rdata  in  8  external read data
- mem_ack  in  1  access complete; sampled only while mem_req=1
- bus_err  out  1  sticky timeout flag

## Operation
- States: IDLE, BUSY.
- Address mux, evaluated in the strobe cycle:
  - PC → pc; GP16 → gp16; WZ → wz.
  - FF_C → {8'hFF, c_reg}.
  - NONE → no access.
- Access start, in IDLE: when (rd_en|wr_en) and addr_sel≠NONE:
  - latch the address, we=wr_en and wdata into registers;
  - assert stall=1;
  - move to BUSY.
- If wr_en and rd_en are both high, the access is a write and rd_en is ignored.
- A strobe with addr_sel=NONE produces stall=0 and no state change.
- BUSY:
  - mem_req=1, with mem_we/mem_addr/mem_wdata driven from the latched registers and held stable until ack.
  - stall = ~mem_ack.
  - On mem_ack: return to IDLE. For a read, also assert rdata_valid=1, drive rdata=mem_rdata combinationally, and capture mem_rdata into rdata_q.
- Outside the ack cycle, rdata=rdata_q.
- Strobes presented while in BUSY are the sequencer's held strobes for the same access; they are not re-latched.
- mem_ack in IDLE is ignored.
- Reset values:
  - state=IDLE;
  - mem_req=0, mem_we=0, mem_addr=16'h0000, mem_wdata=8'h00;
  - rdata_q=8'h00;
  - stall=0, rdata_valid=0, bus_err=0.
- Reset asserted mid-access drops mem_req immediately (asynchronously). The pending access is abandoned.

## Timing
- Strobe in cycle N puts the unit in BUSY at N+1.
- With mem_ack at N+1, the access completes at N+1: stall is 1 in N, 0 in N+1.
- Minimum access is 2 cycles. Each cycle of ack delay adds one stall cycle.
- Back-to-back: the unit is in IDLE at N+2 and accepts a new strobe in that same cycle. There is no dead cycle.
- rdata_valid is a 1-cycle pulse coincident with stall falling.

## Configuration
- SM83_BUS_TIMEOUT_EN defined:
  - A counter runs in BUSY; it is cleared on entry to BUSY and on completion.
  - After TIMEOUT_CYCLES BUSY cycles without ack, the next cycle is a forced completion: stall=0, mem_req drops next cycle, state→IDLE.
  - A forced read returns rdata=8'hFF with rdata_valid=1. A forced write is discarded.
  - bus_err sets to 1 and clears only on reset.
  - An ack arriving in the same cycle as the timeout wins, and bus_err is not set.
- Undefined: no counter; BUSY waits indefinitely; bus_err is tied to 0. The port still exists.

## Structure
- sm83_pkg holds:
  - bus_state_t (IDLE, BUSY);
  - the constant BUS_OPEN_DATA = 8'hFF;
  - addr_sel_t, unchanged.
- One sub-module, sm83_addr_mux: a combinational addr_sel/pc/gp16/wz/c_reg → 16-bit address plus a valid bit (valid=0 for NONE).

## Test plan
- Read at PC=16'h0150, ack in the first BUSY cycle, mem_rdata=8'h3E → mem_addr=16'h0150, stall pattern 1,0, rdata_valid pulse with rdata=8'h3E, rdata_q=8'h3E afterwards.
- Write addr_sel=GP16, gp16=16'hC000, wdata=8'hA5, ack delayed 3 cycles → mem_we=1 and addr/data held stable throughout, stall high for 4 cycles, no rdata_valid.
- addr_sel=FF_C with c_reg=8'h44, read → mem_addr=16'hFF44.
- rd_en=wr_en=1 → exactly one write access. addr_sel=NONE with rd_en → mem_req never asserts, stall=0.
- Two back-to-back reads (PC then WZ=16'h1234), both acked immediately → second mem_req rises the cycle after the first ack, total 4 cycles.
- SM83_BUS_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no ack → read forced with rdata=8'hFF, bus_err=1 sticky. Reset asserted mid-BUSY → mem_req=0 immediately, bus_err=0.
